btn_debounce_pulse: RTL
=======================

// Module: btn_debounce_pulse
// PURPOSE
//  Front-end conditioner for the lock's on/off push-buttons. Per channel:
//  synchronises the raw pad, debounces it, and emits one-cycle press and
//  release pulses. Press pulses go straight to the lock FSM as onpulse/offpulse,
//  replacing the bare synchroniser + level-to-pulse pair. Runs on the fast
//  system clock; no divided clock is needed.
// PARAMETERS
//  N_BTN        2        number of independent button channels
//  SYNC_STAGES  2        synchroniser depth, >=2
//  DB_CYCLES    1000000  consecutive stable clocks to accept a change
//                        (10 ms at 100 MHz); >=2
//  CNT_W        $clog2(DB_CYCLES)  debounce counter width
//                        (derived, not overridden)
// PORTS
//  clk            in   1      system clock, all flops on posedge
//  rst            in   1      asynchronous, active-low reset
//                              (0 = reset asserted)
//  btn_raw        in   N_BTN  raw asynchronous button pads, 1 = pressed
//  btn_level      out  N_BTN  debounced button level
//  press_pulse    out  N_BTN  1-cycle pulse on accepted 0->1 of btn_level
//  release_pulse  out  N_BTN  1-cycle pulse on accepted 1->0 of btn_level
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): clears all sync flops, counters, btn_level,
//    press_pulse and release_pulse to 0. Every channel enters LOW.
//  - Synchroniser: s[i] is btn_raw[i] delayed by SYNC_STAGES posedges.
//  - Per-channel FSM has 4 states: LOW, LOW_PEND, HIGH, HIGH_PEND.
//    LOW      : s=1 -> LOW_PEND, cnt<=1; else stay, cnt<=0.
//    LOW_PEND : s=0 -> LOW, cnt<=0 (bounce, restart).
//               s=1 and cnt==DB_CYCLES-1 -> HIGH, cnt<=0,
//                 btn_level<=1, press_pulse<=1.
//               s=1 otherwise -> cnt<=cnt+1.
//    HIGH / HIGH_PEND: mirror of the above with s inverted.
//                 Acceptance sets btn_level<=0 and release_pulse<=1.
//  - All outputs are registered. Each pulse lasts exactly 1 cycle and
//    coincides with the btn_level edge.
//  - A clean raw edge reaches btn_level after SYNC_STAGES+DB_CYCLES posedges.
//  - Any single-cycle reversal of s during PEND restarts the full
//    DB_CYCLES window. Glitches shorter than DB_CYCLES clocks never
//    change btn_level.
//  - press_pulse and release_pulse of one channel are never high together.
//    Min spacing between opposite pulses on a channel is DB_CYCLES clocks.
//  - Channels are fully independent. Simultaneous events on several
//    channels produce simultaneous pulses.
//  - Counter never exceeds DB_CYCLES-1 (no wrap).
//  - Reset mid-PEND discards the pending change.
//  - Button held through reset: after rst releases, a press_pulse fires
//    SYNC_STAGES+DB_CYCLES clocks later. A held button is treated as a
//    fresh press.
// TESTING (bench overrides DB_CYCLES=4, SYNC_STAGES=2, N_BTN=2)
//  1 Reset: rst=0 with btn_raw=2'b11 -> all outputs 0.
//    Release rst with btn_raw held -> press_pulse=2'b11 at clock 6, 1 cycle.
//  2 Clean press: btn_raw[0] 0->1 held -> btn_level[0]=1 and press_pulse[0]=1
//    exactly 6 clocks later, pulse width 1. Channel 1 stays quiet.
//  3 Bounce: btn_raw[0] toggles 1,0,1,1,0 then held 1 -> no pulse during
//    bounce; single press_pulse 6 clocks after final stable 1.
//  4 Short glitch: btn_raw[1] high 3 clocks then low -> btn_level[1] and
//    press_pulse[1] stay 0 throughout.
//  5 Release: from HIGH, btn_raw[0] 1->0 held -> release_pulse[0]=1 once,
//    6 clocks later, btn_level[0]=0. No press_pulse.
//  6 Reset mid-PEND: assert rst 2 clocks into LOW_PEND -> outputs 0
//    immediately (asynchronously). No stale pulse after release.

Source files
------------

// File: rtl/btn_debounce_pulse.sv
// Button front-end conditioner: per-channel synchroniser, debounce FSM and
// one-cycle press/release pulse generation. All outputs come from flops.
module btn_debounce_pulse #(
    parameter int N_BTN       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse
);

    // Counter only has to hold values up to DB_CYCLES-1.
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_LOW_PEND  = 2'd1,
        ST_HIGH      = 2'd2,
        ST_HIGH_PEND = 2'd3
    } state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s_s;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   press_q, press_d;
        logic                   rel_q, rel_d;

        assign s_s = sync_q[SYNC_STAGES-1];

        // Shift the raw pad through the synchroniser chain.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q <= {SYNC_STAGES{1'b0}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
            end
        end

        // Debounce next-state: a change is accepted only after the
        // synchronised input has held the new value for DB_CYCLES clocks;
        // any reversal while pending drops back and restarts the window.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
                ST_LOW: begin
                    if (s_s) begin
                        state_d = ST_LOW_PEND;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = CNT_ZERO;
                    end
                end
                ST_LOW_PEND: begin
                    if (!s_s) begin
                        state_d = ST_LOW;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_ZERO;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!s_s) begin
                        state_d = ST_HIGH_PEND;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = CNT_ZERO;
                    end
                end
                ST_HIGH_PEND: begin
                    if (s_s) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_LOW;
                        cnt_d   = CNT_ZERO;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b0;
                end
            endcase
        end

        // Debounce state, counter and registered outputs.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= ST_LOW;
                cnt_q   <= CNT_ZERO;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        assign btn_level[i]     = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = rel_q;
    end

endmodule
